// File: rtl/vga_pkg.sv
// Shared timing defaults, axis timing record and graticule levels for the VGA scan generator.
// The graticule logic in vga_timing_gen is only built when VGA_GRATICULE_EN is defined.
package vga_pkg;

   // Default 640x480@60 timing, in pixels and lines
   localparam int unsigned CLK_DIV_DEF    = 2;
   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned H_FP_DEF       = 16;
   localparam int unsigned H_SYNC_DEF     = 96;
   localparam int unsigned H_BP_DEF       = 48;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned V_FP_DEF       = 10;
   localparam int unsigned V_SYNC_DEF     = 2;
   localparam int unsigned V_BP_DEF       = 33;
   localparam int unsigned WAVE_LINES_DEF = 384;
   localparam int unsigned X_DIV_DEF      = 64;
   localparam int unsigned Y_DIV_DEF      = 48;
   localparam int unsigned CW_DEF         = 10;

   localparam logic [7:0] MAJOR_LEVEL_DEF = 8'd255;
   localparam logic [7:0] MINOR_LEVEL_DEF = 8'd122;

   // One scan axis: visible span followed by front porch, sync and back porch
   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } vga_timing_t;

   localparam vga_timing_t H_TIMING_DEF = '{
      active: 16'(H_ACTIVE_DEF), fp: 16'(H_FP_DEF), sync: 16'(H_SYNC_DEF), bp: 16'(H_BP_DEF)
   };
   localparam vga_timing_t V_TIMING_DEF = '{
      active: 16'(V_ACTIVE_DEF), fp: 16'(V_FP_DEF), sync: 16'(V_SYNC_DEF), bp: 16'(V_BP_DEF)
   };

   // Full period of an axis in pixels or lines
   function automatic int unsigned total(input vga_timing_t t);
      return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: enabled wrap-around counter with active-region and sync-window decode.
// active_c, sync_c and wrap_c are combinational decodes of the registered count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter vga_timing_t TIM = H_TIMING_DEF,
   parameter int unsigned CW  = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          active_c,
   output logic          sync_c,
   output logic          wrap_c
);

   localparam int unsigned TOTAL   = total(TIM);
   localparam int unsigned ACT_END = 32'(TIM.active);
   localparam int unsigned SYNC_LO = 32'(TIM.active) + 32'(TIM.fp);
   localparam int unsigned SYNC_HI = SYNC_LO + 32'(TIM.sync);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Advance on enable, folding back to zero after the last position of the axis
   always_comb begin
      count_d = count_q;
      wrap_c  = en_i && (32'(count_q) == (TOTAL - 1));
      if (wrap_c) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Region decode of the current position
   always_comb begin
      active_c = 32'(count_q) < ACT_END;
      sync_c   = (32'(count_q) >= SYNC_LO) && (32'(count_q) < SYNC_HI);
   end

   assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA scan generator: pixel clock enable, scan coordinates, syncs,
// display enables, line/frame strobes and scope graticule intensity, all registered
// and aligned to the same pixel one pixel after the scan counters.
// Define VGA_GRATICULE_EN to build the graticule; otherwise grid is held at zero.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter logic        SYNC_POL    = 1'b0,
   parameter int unsigned WAVE_LINES  = WAVE_LINES_DEF,
   parameter int unsigned X_DIV       = X_DIV_DEF,
   parameter int unsigned Y_DIV       = Y_DIV_DEF,
   parameter logic [7:0]  MAJOR_LEVEL = MAJOR_LEVEL_DEF,
   parameter logic [7:0]  MINOR_LEVEL = MINOR_LEVEL_DEF,
   parameter int unsigned CW          = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          pix_ce,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          de,
   output logic          wave_de,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    grid
);

   localparam vga_timing_t H_TIM = '{
      active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)
   };
   localparam vga_timing_t V_TIM = '{
      active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)
   };
   localparam int unsigned       H_TOTAL  = total(H_TIM);
   localparam int unsigned       V_TOTAL  = total(V_TIM);
   localparam longint unsigned   CW_CAP   = 64'd1 << CW;
   localparam int unsigned       DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]     CNT_LAST = DW'(CLK_DIV - 1);

   // Elaboration-time parameter legality
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_bad_sync
      $error("vga_timing_gen: H_SYNC and V_SYNC must be non-zero");
   end
   if (WAVE_LINES > V_ACTIVE) begin : g_bad_wave
      $error("vga_timing_gen: WAVE_LINES must not exceed V_ACTIVE");
   end
   if ((CW_CAP < 64'(H_TOTAL)) || (CW_CAP < 64'(V_TOTAL))) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end
   if ((X_DIV < 1) || (Y_DIV < 1)) begin : g_bad_div_pitch
      $error("vga_timing_gen: X_DIV and Y_DIV must be at least 1");
   end

   logic [DW-1:0] cnt_q, cnt_d;
   logic          pix_ce_q, pix_ce_d;

   // Pixel divider; the enable is registered so it lines up with cnt == CLK_DIV-1
   always_comb begin
      cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + DW'(1);
      pix_ce_d = (cnt_d == CNT_LAST);
   end

   // Divider registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         pix_ce_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pix_ce_q <= pix_ce_d;
      end
   end

   logic [CW-1:0] hc, vc;
   logic          h_active, h_sync, h_wrap;
   logic          v_active, v_sync, v_wrap;

   vga_axis_counter #(.TIM(H_TIM), .CW(CW)) u_h_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (pix_ce_q),
      .count_o  (hc),
      .active_c (h_active),
      .sync_c   (h_sync),
      .wrap_c   (h_wrap)
   );

   vga_axis_counter #(.TIM(V_TIM), .CW(CW)) u_v_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (h_wrap),
      .count_o  (vc),
      .active_c (v_active),
      .sync_c   (v_sync),
      .wrap_c   (v_wrap)
   );

   logic       de_c, wave_c;
   logic [7:0] grid_c;

   // Display regions of the pixel currently held in hc/vc
   always_comb begin
      de_c   = h_active && v_active;
      wave_c = de_c && (32'(vc) < WAVE_LINES);
   end

`ifdef VGA_GRATICULE_EN
   localparam int unsigned XW = (X_DIV > 1) ? $clog2(X_DIV) : 1;
   localparam int unsigned YW = (Y_DIV > 1) ? $clog2(Y_DIV) : 1;

   logic [XW-1:0] xd_q, xd_d;
   logic [YW-1:0] yd_q, yd_d;
   logic          major_c, minor_c;

   // Minor pitch counters track hc mod X_DIV and vc mod Y_DIV without dividers
   always_comb begin
      xd_d = xd_q;
      yd_d = yd_q;
      if (h_wrap) begin
         xd_d = '0;
      end else if (pix_ce_q) begin
         xd_d = (32'(xd_q) == (X_DIV - 1)) ? '0 : xd_q + XW'(1);
      end
      if (v_wrap) begin
         yd_d = '0;
      end else if (h_wrap) begin
         yd_d = (32'(yd_q) == (Y_DIV - 1)) ? '0 : yd_q + YW'(1);
      end
   end

   // Pitch counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xd_q <= '0;
         yd_q <= '0;
      end else begin
         xd_q <= xd_d;
         yd_q <= yd_d;
      end
   end

   // Graticule intensity; major lines win over minor dots, nothing outside the waveform area
   always_comb begin
      major_c = (32'(hc) == 1) || (32'(hc) == (H_ACTIVE / 2)) || (32'(hc) == (H_ACTIVE - 4)) ||
                (32'(vc) == 1) || (32'(vc) == (WAVE_LINES / 2)) || (32'(vc) == (WAVE_LINES - 1));
      minor_c = ((xd_q == '0) && vc[0]) || ((yd_q == '0) && hc[0]);
      grid_c  = 8'd0;
      if (wave_c) begin
         if (major_c) begin
            grid_c = MAJOR_LEVEL;
         end else if (minor_c) begin
            grid_c = MINOR_LEVEL;
         end
      end
   end
`else
   logic [33:0] unused_grat;

   // Graticule not built
   always_comb begin
      grid_c      = 8'd0;
      unused_grat = {v_wrap, MAJOR_LEVEL, MINOR_LEVEL, X_DIV[7:0], Y_DIV[7:0]};
   end
`endif

   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic          de_q, de_d, wave_q, wave_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          ls_q, ls_d, fs_q, fs_d;
   logic          valid_q, valid_d;
   logic [7:0]    grid_q, grid_d;

   // Output stage: latch the current pixel on pix_ce; strobes fire on the pix_ce that
   // closes a real (post-reset) x==0 pixel so they last one clk and meet pix_ce
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      de_d    = de_q;
      wave_d  = wave_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      grid_d  = grid_q;
      if (pix_ce_q) begin
         x_d     = hc;
         y_d     = vc;
         de_d    = de_c;
         wave_d  = wave_c;
         hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
         vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
         grid_d  = grid_c;
      end
      valid_d = valid_q || pix_ce_q;
      ls_d    = pix_ce_d && valid_d && (x_d == '0);
      fs_d    = ls_d && (y_d == '0);
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         de_q    <= 1'b0;
         wave_q  <= 1'b0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         valid_q <= 1'b0;
         grid_q  <= 8'd0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         de_q    <= de_d;
         wave_q  <= wave_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         valid_q <= valid_d;
         grid_q  <= grid_d;
      end
   end

   assign pix_ce      = pix_ce_q;
   assign x           = x_q;
   assign y           = y_q;
   assign de          = de_q;
   assign wave_de     = wave_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign grid        = grid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing, a reduced timing that fits a full
// frame, and the tiny CLK_DIV=1 timing. Expected pixels are queued from a formula model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed {
      int unsigned cdiv, ha, hfp, hs, hbp, va, vfp, vs, vbp, wl, xdiv, ydiv;
   } cfg_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de, wave, hs, vs, ls, fs;
      logic [7:0] grid;
   } pix_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de, wave;
      logic [7:0] g;
   } pt_t;

   localparam cfg_t CD = '{cdiv:2, ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33,
                           wl:384, xdiv:64, ydiv:48};
   localparam cfg_t CM = '{cdiv:1, ha:40, hfp:2, hs:3, hbp:3, va:30, vfp:2, vs:2, vbp:2,
                           wl:24, xdiv:8, ydiv:6};
   localparam cfg_t CS = '{cdiv:1, ha:8, hfp:2, hs:2, hbp:2, va:4, vfp:1, vs:1, vbp:1,
                           wl:4, xdiv:4, ydiv:2};

`ifdef VGA_GRATICULE_EN
   localparam logic [7:0] GMAJ = 8'd255;
   localparam logic [7:0] GMIN = 8'd122;
`else
   localparam logic [7:0] GMAJ = 8'd0;
   localparam logic [7:0] GMIN = 8'd0;
`endif

   localparam pix_t RST_PIX = '{x:10'd0, y:10'd0, de:1'b0, wave:1'b0, hs:1'b1, vs:1'b1,
                                ls:1'b0, fs:1'b0, grid:8'd0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d, rst_m, rst_s;
   logic       d_ce, d_de, d_wave, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_x, d_y;
   logic [7:0] d_grid;
   logic       m_ce, m_de, m_wave, m_hs, m_vs, m_ls, m_fs;
   logic [9:0] m_x, m_y;
   logic [7:0] m_grid;
   logic       s_ce, s_de, s_wave, s_hs, s_vs, s_ls, s_fs;
   logic [9:0] s_x, s_y;
   logic [7:0] s_grid;

   vga_timing_gen #(.CLK_DIV(CD.cdiv), .H_ACTIVE(CD.ha), .H_FP(CD.hfp), .H_SYNC(CD.hs),
      .H_BP(CD.hbp), .V_ACTIVE(CD.va), .V_FP(CD.vfp), .V_SYNC(CD.vs), .V_BP(CD.vbp),
      .WAVE_LINES(CD.wl), .X_DIV(CD.xdiv), .Y_DIV(CD.ydiv), .CW(10)) u_def (
      .clk(clk), .rst_n(rst_d), .pix_ce(d_ce), .x(d_x), .y(d_y), .de(d_de), .wave_de(d_wave),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .grid(d_grid));

   vga_timing_gen #(.CLK_DIV(CM.cdiv), .H_ACTIVE(CM.ha), .H_FP(CM.hfp), .H_SYNC(CM.hs),
      .H_BP(CM.hbp), .V_ACTIVE(CM.va), .V_FP(CM.vfp), .V_SYNC(CM.vs), .V_BP(CM.vbp),
      .WAVE_LINES(CM.wl), .X_DIV(CM.xdiv), .Y_DIV(CM.ydiv), .CW(10)) u_mid (
      .clk(clk), .rst_n(rst_m), .pix_ce(m_ce), .x(m_x), .y(m_y), .de(m_de), .wave_de(m_wave),
      .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs), .grid(m_grid));

   vga_timing_gen #(.CLK_DIV(CS.cdiv), .H_ACTIVE(CS.ha), .H_FP(CS.hfp), .H_SYNC(CS.hs),
      .H_BP(CS.hbp), .V_ACTIVE(CS.va), .V_FP(CS.vfp), .V_SYNC(CS.vs), .V_BP(CS.vbp),
      .WAVE_LINES(CS.wl), .X_DIV(CS.xdiv), .Y_DIV(CS.ydiv), .CW(10)) u_small (
      .clk(clk), .rst_n(rst_s), .pix_ce(s_ce), .x(s_x), .y(s_y), .de(s_de), .wave_de(s_wave),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs), .grid(s_grid));

   int   sel;
   logic obs_ce;
   pix_t obs;

   // Route the instance under test to one observation point
   always_comb begin
      case (sel)
         1:       begin obs_ce = m_ce; obs = '{m_x, m_y, m_de, m_wave, m_hs, m_vs, m_ls, m_fs, m_grid}; end
         2:       begin obs_ce = s_ce; obs = '{s_x, s_y, s_de, s_wave, s_hs, s_vs, s_ls, s_fs, s_grid}; end
         default: begin obs_ce = d_ce; obs = '{d_x, d_y, d_de, d_wave, d_hs, d_vs, d_ls, d_fs, d_grid}; end
      endcase
   end

   int unsigned checks = 0;
   int unsigned errors = 0;
   pix_t exp_q[$];
   pt_t  pts[$];

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference pixel k of the scan, counted from the first real pixel after reset
   function automatic pix_t exp_pix(input cfg_t c, input int unsigned k);
      int unsigned ht, vt, px, py;
      pix_t p;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      px = k % ht;
      py = (k / ht) % vt;
      p.x    = 10'(px);
      p.y    = 10'(py);
      p.de   = (px < c.ha) && (py < c.va);
      p.wave = p.de && (py < c.wl);
      p.hs   = !((px >= c.ha + c.hfp) && (px < c.ha + c.hfp + c.hs));
      p.vs   = !((py >= c.va + c.vfp) && (py < c.va + c.vfp + c.vs));
      p.ls   = (px == 0);
      p.fs   = (px == 0) && (py == 0);
      p.grid = 8'd0;
      if (p.wave) begin
         if (px == 1 || px == c.ha / 2 || px == c.ha - 4 || py == 1 || py == c.wl / 2 || py == c.wl - 1)
            p.grid = GMAJ;
         else if (((px % c.xdiv) == 0 && (py % 2) == 1) || ((py % c.ydiv) == 0 && (px % 2) == 1))
            p.grid = GMIN;
      end
      return p;
   endfunction

   // Queue expected pixels, then pop one per pix_ce and compare; off-enable clocks carry no strobes
   task automatic run_pixels(input cfg_t c, input int unsigned k0, input int unsigned n,
                             input bit dummy, input bit directed,
                             output int unsigned n_ls, output int unsigned n_fs, output int unsigned n_de);
      pix_t e, o;
      int unsigned gap, clk_n, last_ls, last_fs, idx, ht, vt;
      bit seen_ce, seen_ls, seen_fs;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      n_ls = 0; n_fs = 0; n_de = 0;
      gap = 0; clk_n = 0; last_ls = 0; last_fs = 0; idx = 0;
      seen_ce = 0; seen_ls = 0; seen_fs = 0;
      exp_q.delete();
      if (dummy) exp_q.push_back(RST_PIX);
      for (int unsigned k = 0; k < n; k++) exp_q.push_back(exp_pix(c, k0 + k));
      while (exp_q.size() > 0) begin
         @(negedge clk);
         clk_n++;
         gap++;
         if (gap > c.cdiv + 4) begin
            check("pix_ce_timeout", 64'(gap), 64'(c.cdiv));
            return;
         end
         o = obs;
         if (!obs_ce) begin
            check("strobe_off_ce", 64'({o.ls, o.fs}), 64'(2'b00));
            continue;
         end
         if (seen_ce) check("pix_ce_period", 64'(gap), 64'(c.cdiv));
         seen_ce = 1;
         gap = 0;
         e = exp_q.pop_front();
         check($sformatf("pixel#%0d x=%0d y=%0d", idx, e.x, e.y), 64'(o), 64'(e));
         idx++;
         if (o.ls) begin
            if (seen_ls) check("line_period_clk", 64'(clk_n - last_ls), 64'(ht * c.cdiv));
            seen_ls = 1; last_ls = clk_n; n_ls++;
         end
         if (o.fs) begin
            if (seen_fs) check("frame_period_clk", 64'(clk_n - last_fs), 64'(ht * vt * c.cdiv));
            seen_fs = 1; last_fs = clk_n; n_fs++;
         end
         if (o.de) n_de++;
         if (directed) begin
            foreach (pts[i]) begin
               if (pts[i].x == o.x && pts[i].y == o.y)
                  check($sformatf("point(%0d,%0d)", o.x, o.y), 64'({o.de, o.wave, o.grid}),
                        64'({pts[i].de, pts[i].wave, pts[i].g}));
            end
         end
      end
   endtask

   // Hard stop if the sequence ever stalls
   initial begin
      #2ms;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned nls, nfs, nde;
      sel = 0; rst_d = 1'b0; rst_m = 1'b0; rst_s = 1'b0;
      pts.push_back('{10'd20, 10'd5,  1'b1, 1'b1, GMAJ});
      pts.push_back('{10'd8,  10'd7,  1'b1, 1'b1, GMIN});
      pts.push_back('{10'd8,  10'd8,  1'b1, 1'b1, 8'd0});
      pts.push_back('{10'd10, 10'd6,  1'b1, 1'b1, 8'd0});
      pts.push_back('{10'd11, 10'd6,  1'b1, 1'b1, GMIN});
      pts.push_back('{10'd10, 10'd26, 1'b1, 1'b0, 8'd0});
      pts.push_back('{10'd39, 10'd29, 1'b1, 1'b0, 8'd0});
      pts.push_back('{10'd40, 10'd29, 1'b0, 1'b0, 8'd0});
      pts.push_back('{10'd5,  10'd23, 1'b1, 1'b1, GMAJ});
      pts.push_back('{10'd5,  10'd24, 1'b1, 1'b0, 8'd0});
      pts.push_back('{10'd36, 10'd13, 1'b1, 1'b1, GMAJ});

      // Reset state of every instance
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset_pixel inst%0d", s), 64'(obs), 64'(RST_PIX));
         check($sformatf("reset_pix_ce inst%0d", s), 64'(obs_ce), 64'(0));
      end

      // Default timing: two full lines and into the third, up to x=300
      sel = 0;
      @(negedge clk);
      rst_d = 1'b1;
      run_pixels(CD, 0, 2 * 800 + 301, 1'b1, 1'b0, nls, nfs, nde);
      check("def_line_starts", 64'(nls), 64'(3));
      check("def_frame_starts", 64'(nfs), 64'(1));
      check("def_de_pixels", 64'(nde), 64'(2 * 640 + 301));

      // Mid-frame reset at x=300: outputs drop at once and the scan restarts at (0,0)
      rst_d = 1'b0;
      #1;
      check("midrst_pixel_now", 64'(obs), 64'(RST_PIX));
      check("midrst_pix_ce_now", 64'(obs_ce), 64'(0));
      repeat (3) @(negedge clk);
      check("midrst_pixel_held", 64'(obs), 64'(RST_PIX));
      rst_d = 1'b1;
      run_pixels(CD, 0, 805, 1'b1, 1'b0, nls, nfs, nde);
      check("def_restart_line_starts", 64'(nls), 64'(2));
      check("def_restart_frame_starts", 64'(nfs), 64'(1));

      // Reduced timing: one full frame plus the start of the next
      sel = 1;
      @(negedge clk);
      rst_m = 1'b1;
      run_pixels(CM, 0, 48 * 36 + 60, 1'b1, 1'b1, nls, nfs, nde);
      check("mid_line_starts", 64'(nls), 64'(36 + 2));
      check("mid_frame_starts", 64'(nfs), 64'(2));
      check("mid_de_pixels", 64'(nde), 64'(40 * 30 + 40 + 12));

      // Tiny CLK_DIV=1 timing: 14-clk lines, 98-clk frames
      sel = 2;
      @(negedge clk);
      rst_s = 1'b1;
      run_pixels(CS, 0, 2 * 98 + 5, 1'b1, 1'b0, nls, nfs, nde);
      check("small_line_starts", 64'(nls), 64'(15));
      check("small_frame_starts", 64'(nfs), 64'(3));
      check("small_de_pixels", 64'(nde), 64'(2 * 32 + 5));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
